// File: rtl/cnu_minfind_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cnu_minfind_seq
// Purpose  : Serial min1/min2/index/sign-parity finder for one check-node row.
// Revision : 1.0 - initial release
// ============================================================================
module cnu_minfind_seq #(
    parameter int QUAN_SIZE = 3,
    parameter int CN_DEGREE = 10,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] in_mag,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE-1:0] out_min1,
    output logic [QUAN_SIZE-1:0] out_min2,
    output logic [IDX_WIDTH-1:0] out_min_idx,
    output logic                 out_sign_prod,
    output logic                 busy
);

    localparam logic [0:0]           C_ACCUM = 1'b0;
    localparam logic [0:0]           C_HOLD  = 1'b1;
    localparam logic [IDX_WIDTH-1:0] C_LAST  = IDX_WIDTH'(CN_DEGREE - 1);

    logic [0:0]           r_state;
    logic [IDX_WIDTH-1:0] r_cnt;
    logic [QUAN_SIZE-1:0] r_min1;
    logic [QUAN_SIZE-1:0] r_min2;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 r_par;
    logic [QUAN_SIZE-1:0] r_out_min1;
    logic [QUAN_SIZE-1:0] r_out_min2;
    logic [IDX_WIDTH-1:0] r_out_idx;
    logic                 r_out_par;
    logic                 r_busy;

    logic [QUAN_SIZE-1:0] w_min1;
    logic [QUAN_SIZE-1:0] w_min2;
    logic [IDX_WIDTH-1:0] w_idx;
    logic                 w_par;

    // Running state after folding in the current message; position 0 seeds it.
    always_comb begin
        w_min1 = r_min1;
        w_min2 = r_min2;
        w_idx  = r_idx;
        w_par  = r_par ^ in_sign;
        if (r_cnt == '0) begin
            w_min1 = in_mag;
            w_min2 = '1;
            w_idx  = '0;
            w_par  = in_sign;
        end else if (in_mag < r_min1) begin
            w_min2 = r_min1;
            w_min1 = in_mag;
            w_idx  = r_cnt;
        end else if (in_mag < r_min2) begin
            w_min2 = in_mag;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= C_ACCUM;
            r_cnt      <= '0;
            r_min1     <= '1;
            r_min2     <= '1;
            r_idx      <= '0;
            r_par      <= 1'b0;
            r_out_min1 <= '1;
            r_out_min2 <= '1;
            r_out_idx  <= '0;
            r_out_par  <= 1'b0;
            r_busy     <= 1'b0;
        end else if (abort) begin
            if (r_state == C_ACCUM) begin
                r_cnt  <= '0;
                r_min1 <= '1;
                r_min2 <= '1;
                r_idx  <= '0;
                r_par  <= 1'b0;
            end
            r_state <= C_ACCUM;
            r_busy  <= 1'b0;
        end else if (r_state == C_ACCUM) begin
            if (in_valid) begin
                r_min1 <= w_min1;
                r_min2 <= w_min2;
                r_idx  <= w_idx;
                r_par  <= w_par;
                r_busy <= 1'b1;
                if (r_cnt == C_LAST) begin
                    r_cnt      <= '0;
                    r_state    <= C_HOLD;
                    r_out_min1 <= w_min1;
                    r_out_min2 <= w_min2;
                    r_out_idx  <= w_idx;
                    r_out_par  <= w_par;
                end else begin
                    r_cnt <= r_cnt + IDX_WIDTH'(1);
                end
            end
        end else if (out_ready) begin
            r_state <= C_ACCUM;
            r_busy  <= 1'b0;
        end
    end

    assign in_ready      = (r_state == C_ACCUM);
    assign out_valid     = (r_state == C_HOLD);
    assign out_min1      = r_out_min1;
    assign out_min2      = r_out_min2;
    assign out_min_idx   = r_out_idx;
    assign out_sign_prod = r_out_par;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: doc/cnu_minfind_seq.md
Name: cnu_minfind_seq

Overview:
- Serial min-finder sequencer for the check-node update.
- Accepts one variable-to-check message per cycle over a valid/ready handshake, across a row of CN_DEGREE messages.
- Tracks the smallest magnitude (min1), its position index, the second-smallest magnitude (min2) and the running sign parity.
- Presents the row result on a held valid/ready output port; it replaces a parallel compare tree when the row is time-multiplexed.

Parameters:
- QUAN_SIZE, 3: magnitude width in bits.
- CN_DEGREE, 10: messages per row, legal range 2..16.
- IDX_WIDTH, 4: index width; must satisfy 2^IDX_WIDTH >= CN_DEGREE.

Ports:
- sys_clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- abort, input, 1: synchronous frame discard.
- in_valid, input, 1: message present.
- in_ready, output, 1: block accepts a message this cycle.
- in_mag, input, QUAN_SIZE: message magnitude, unsigned.
- in_sign, input, 1: message sign, 1 = negative.
- out_valid, output, 1: row result valid.
- out_ready, input, 1: consumer takes the result.
- out_min1, output, QUAN_SIZE: smallest magnitude in the row.
- out_min2, output, QUAN_SIZE: second-smallest magnitude in the row.
- out_min_idx, output, IDX_WIDTH: position (0-based arrival order) of min1.
- out_sign_prod, output, 1: XOR of all in_sign values in the row.
- busy, output, 1: at least one message of the current row accepted, result not yet consumed.

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset rst is synchronous and active-high.
- Reset state:
  - FSM goes to ACCUM and the position counter to 0.
  - out_valid=0 and busy=0.
  - out_min1 = out_min2 = all ones; out_min_idx=0; out_sign_prod=0.
  - Reset mid-row discards the partial row; no result is emitted.
- FSM has two states, ACCUM and HOLD.
  - in_ready = (state==ACCUM) and is combinational from state only.
  - out_valid = (state==HOLD).
- Accept: occurs when in_valid && in_ready, with cnt = position counter.
  - cnt==0: min1<=in_mag, min2<=all ones, idx<=0, par<=in_sign.
  - cnt>0, in_mag < min1 (strict): min2<=min1, min1<=in_mag, idx<=cnt.
  - cnt>0, else if in_mag < min2 (strict): min2<=in_mag.
  - par<=par^in_sign on every accept.
  - Ties: the earliest position keeps min1. A later equal value may become min2, so min2 equals min1 when the minimum repeats.
  - cnt increments on each accept. On the accept with cnt==CN_DEGREE-1, cnt<=0 and state<=HOLD.
- Latency: out_valid rises on the cycle after the last message of the row is accepted. Output registers are updated in that same edge.
- HOLD:
  - Outputs are held stable while out_ready=0; in_valid is ignored and in_ready=0.
  - out_valid && out_ready in the same cycle returns the FSM to ACCUM on the next edge.
  - in_ready=1 from the next cycle, so there is one bubble between rows.
- Output registers keep their last values after consumption until the next row completes.
- busy is 1 from the first accept of a row until the handshake cycle of its result.
- abort:
  - In ACCUM: clears cnt and par and the partial min state; busy<=0; output registers are unchanged.
  - In HOLD: drops the pending result (out_valid<=0, state<=ACCUM).
  - abort and in_valid in the same cycle: abort wins and the message is not accepted.
  - rst has priority over abort.
- No arithmetic overflow is possible; all comparisons are unsigned at QUAN_SIZE width.

Test Plan:
1. Basic row, defaults, no stall:
   - Stimulus: mags 5,3,7,3,1,6,2,4,7,5; signs 1,0,0,1,0,0,0,1,0,0.
   - Response: out_valid the cycle after the 10th accept; min1=1, min2=2, idx=4, sign_prod=1.
2. Repeated values:
   - Stimulus: mags all 7. Response: min1=7, min2=7, idx=0.
   - Stimulus: 4,2,2,6,6,6,6,6,6,6. Response: min1=2, idx=1, min2=2.
3. Output backpressure:
   - Stimulus: out_ready=0 for 5 cycles after out_valid, with in_valid held at 1.
   - Response: outputs constant, in_ready=0, no accepts.
   - After out_ready=1: in_ready=1 on the next cycle, and the next row starts at idx 0.
4. Input gaps:
   - Stimulus: in_valid toggled 1,0,1,0 across the row of test 1.
   - Response: same result as test 1; cnt advances only on accepts.
5. Reset mid-row:
   - Stimulus: rst pulsed after 4 accepts, then the row 6,6,6,6,6,6,6,6,6,0 is sent.
   - Response: out_valid=0 during and after reset; final result min1=0, idx=9, min2=6.
6. Abort cases:
   - Stimulus: abort together with in_valid after 3 accepts, then a full row.
   - Response: the abort-cycle message is not taken; the result reflects only the new 10 messages.
   - Stimulus: abort while in HOLD. Response: out_valid falls on the next cycle.
